conv_window_reader: RTL and testbench
=====================================

// Module: conv_window_reader
// PURPOSE
//  Consumer side of the 3-row column line buffer. Accepts one 3-pixel column per
//  handshake from the line-buffer read ports (row1..row3) and maintains a 3x3
//  sliding window. Emits every valid 3x3 window, tagged with its output row/col,
//  to the convolution PE array. Runs one frame per start pulse, no cross-row windows.
// PARAMETERS
//  BIT_DEPTH  8   pixel width
//  COLS       28  columns per image row (>=3)
//  ROWS_OUT   26  window rows per frame (image rows - 2)
// PORTS
//  clk         in   1             rising-edge clock
//  rst_n       in   1             async active-low reset
//  start       in   1             begin a frame; honoured only in IDLE
//  in_valid    in   1             column on col_r1..r3 valid
//  in_ready    out  1             block accepts a column this cycle
//  col_r1      in   BIT_DEPTH     top-row pixel of column
//  col_r2      in   BIT_DEPTH     middle-row pixel
//  col_r3      in   BIT_DEPTH     bottom-row pixel
//  win_valid   out  1             win_* valid
//  win_ready   in   1             downstream takes window
//  win_data    out  9*BIT_DEPTH   [(r*3+c)*BIT_DEPTH +: BIT_DEPTH], r0=row1, c0=oldest col
//  win_row     out  $clog2(ROWS_OUT) output row index of window
//  win_col     out  $clog2(COLS)  output col index (0..COLS-3)
//  frame_done  out  1             1-cycle pulse after last window handed off
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset asynchronous, active-low (rst_n).
//  Reset: state IDLE; in_ready, win_valid, frame_done, win_data, win_row, win_col,
//   window regs, col_cnt, row_cnt all 0. Reset mid-frame aborts immediately.
//  in_ready = (state==FILL||state==STREAM) && (!win_valid || win_ready). Combinational.
//  Accept = in_valid && in_ready: window shifts c0<=c1, c1<=c2, c2<=col_r*; col_cnt++.
//  FSM:
//   IDLE   : start -> FILL, col_cnt=row_cnt=0. start elsewhere ignored.
//   FILL   : accepts cols 0,1 of a row, no window out; accept at col_cnt==1 -> STREAM.
//   STREAM : each accept -> next cycle win_valid=1, win_data = shifted window,
//            win_col=col_cnt-2, win_row=row_cnt. Accept of col COLS-1: col_cnt->0;
//            row_cnt==ROWS_OUT-1 -> DRAIN, else row_cnt++ -> FILL.
//   DRAIN  : in_ready=0; when !win_valid or win_valid&&win_ready -> frame_done=1 for
//            one cycle, -> IDLE.
//  Handshake: win_valid, once high, holds with win_* stable until win_ready; clears on
//   win_ready with no new accept same cycle; simultaneous handoff+accept keeps
//   win_valid=1 with new data (1 window/cycle sustained).
//  Latency: column accept -> win_valid 1 cycle. Up to 2 columns buffered (FILL).
//  Counters wrap only via FSM above; no window spans two image rows.
//  in_valid while in_ready=0: column held by source, nothing lost or duplicated.
// TESTING
//  1 Ramp, win_ready=1: col n = {r1=n, r2=n+64, r3=n+128}: first win 1 cycle after
//    3rd accept, row1 taps {0,1,2}, row3 {128,129,130}, win_col=0; last of row win_col=25 {25,26,27}.
//  2 Backpressure: win_ready=0 for 5 cycles mid-row -> in_ready=0, win_data stable,
//    after release windows continue with no gap/duplication in win_col.
//  3 Row boundary: after col 27 of row 0, next 2 accepts give no window; next window
//    win_row=1, win_col=0, contains only new-row columns 0..2.
//  4 Full frame, random in_valid/win_ready: exactly 26*26=676 windows, win_row/win_col
//    raster order, one frame_done pulse after final handshake; start mid-frame ignored.
//  5 rst_n low mid-STREAM -> all outputs 0 asynchronously; new start runs clean frame.

Source files
------------

// File: rtl/conv_window_reader.sv
// 3x3 sliding-window builder fed one 3-pixel column per handshake from the line buffer.
// Emits each window tagged with its output row/col; one frame per start pulse.
module conv_window_reader #(
   parameter int unsigned BIT_DEPTH = 8,
   parameter int unsigned COLS      = 28,
   parameter int unsigned ROWS_OUT  = 26
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BIT_DEPTH-1:0]          col_r1,
   input  logic [BIT_DEPTH-1:0]          col_r2,
   input  logic [BIT_DEPTH-1:0]          col_r3,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [9*BIT_DEPTH-1:0]        win_data,
   output logic [$clog2(ROWS_OUT)-1:0]   win_row,
   output logic [$clog2(COLS)-1:0]       win_col,
   output logic                          frame_done
);

   localparam int unsigned ROW_W = $clog2(ROWS_OUT);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned WIN_W = 9 * BIT_DEPTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t             state_q,      state_d;
   logic [COL_W-1:0]   col_cnt_q,    col_cnt_d;
   logic [ROW_W-1:0]   row_cnt_q,    row_cnt_d;
   logic [WIN_W-1:0]   win_q,        win_d;
   logic               win_valid_q,  win_valid_d;
   logic [WIN_W-1:0]   win_data_q,   win_data_d;
   logic [ROW_W-1:0]   win_row_q,    win_row_d;
   logic [COL_W-1:0]   win_col_q,    win_col_d;
   logic               frame_done_q, frame_done_d;

   logic               accept;
   logic [WIN_W-1:0]   win_shift;
   logic [BIT_DEPTH-1:0] col_px [3];

   // Column is taken only while a frame is active and the output slot is free or draining.
   always_comb begin
      in_ready = ((state_q == FILL) || (state_q == STREAM)) && (!win_valid_q || win_ready);
      accept   = in_valid && in_ready;
   end

   // Window after shifting in the incoming column: oldest column drops out of c0.
   always_comb begin
      col_px[0] = col_r1;
      col_px[1] = col_r2;
      col_px[2] = col_r3;
      win_shift = win_q;
      for (int r = 0; r < 3; r++) begin
         win_shift[(r*3+0)*BIT_DEPTH +: BIT_DEPTH] = win_q[(r*3+1)*BIT_DEPTH +: BIT_DEPTH];
         win_shift[(r*3+1)*BIT_DEPTH +: BIT_DEPTH] = win_q[(r*3+2)*BIT_DEPTH +: BIT_DEPTH];
         win_shift[(r*3+2)*BIT_DEPTH +: BIT_DEPTH] = col_px[r];
      end
   end

   always_comb begin
      state_d      = state_q;
      col_cnt_d    = col_cnt_q;
      row_cnt_d    = row_cnt_q;
      win_d        = win_q;
      win_valid_d  = win_valid_q;
      win_data_d   = win_data_q;
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
      frame_done_d = 1'b0;

      if (win_valid_q && win_ready) begin
         win_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = FILL;
               col_cnt_d = '0;
               row_cnt_d = '0;
            end
         end
         FILL: begin
            if (accept) begin
               win_d     = win_shift;
               col_cnt_d = col_cnt_q + COL_W'(1);
               if (col_cnt_q == COL_W'(1)) begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (accept) begin
               win_d       = win_shift;
               win_valid_d = 1'b1;
               win_data_d  = win_shift;
               win_col_d   = col_cnt_q - COL_W'(2);
               win_row_d   = row_cnt_q;
               if (col_cnt_q == COL_W'(COLS - 1)) begin
                  col_cnt_d = '0;
                  if (row_cnt_q == ROW_W'(ROWS_OUT - 1)) begin
                     state_d = DRAIN;
                  end else begin
                     row_cnt_d = row_cnt_q + ROW_W'(1);
                     state_d   = FILL;
                  end
               end else begin
                  col_cnt_d = col_cnt_q + COL_W'(1);
               end
            end
         end
         DRAIN: begin
            if (!win_valid_q || win_ready) begin
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_cnt_q    <= '0;
         row_cnt_q    <= '0;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         win_data_q   <= '0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_cnt_q    <= col_cnt_d;
         row_cnt_q    <= row_cnt_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         win_data_q   <= win_data_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign win_valid  = win_valid_q;
   assign win_data   = win_data_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader: ramp frame with stall, random-handshake frame,
// and asynchronous reset mid-stream.
module tb_conv_window_reader;

   localparam int unsigned BD = 8;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  col_r1, col_r2, col_r3;
   logic        win_valid;
   logic        win_ready;
   logic [71:0] win_data;
   logic [4:0]  win_row;
   logic [4:0]  win_col;
   logic        frame_done;

   int tests = 0;
   int fails = 0;

   int          got;
   int          fd_cnt;
   int          cyc;
   logic        held;
   logic [71:0] hdata;
   logic [4:0]  hcol;

   conv_window_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .col_r1     (col_r1),
      .col_r2     (col_r2),
      .col_r3     (col_r3),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pixel of source row pr, column n, tap row k (0=top).
   function automatic logic [7:0] pix(input int pr, input int n, input int k);
      return 8'(pr * 5 + n + k * 64);
   endfunction

   function automatic logic [71:0] win_exp(input int pr, input int c);
      logic [71:0] w;
      w = '0;
      for (int rr = 0; rr < 3; rr++)
         for (int cc = 0; cc < 3; cc++)
            w[(rr*3+cc)*BD +: BD] = pix(pr, c + cc, rr);
      return w;
   endfunction

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_col(input int pr, input int n);
      col_r1 = pix(pr, n, 0);
      col_r2 = pix(pr, n, 1);
      col_r3 = pix(pr, n, 2);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      win_ready = 1'b0;
      col_r1    = '0;
      col_r2    = '0;
      col_r3    = '0;

      // Reset state
      #1;
      chk("rst_in_ready",   72'(in_ready),   72'(0));
      chk("rst_win_valid",  72'(win_valid),  72'(0));
      chk("rst_frame_done", 72'(frame_done), 72'(0));
      chk("rst_win_data",   win_data,        72'(0));
      chk("rst_win_row",    72'(win_row),    72'(0));
      chk("rst_win_col",    72'(win_col),    72'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 72'(in_ready), 72'(0));

      // Frame 1: full-rate ramp, one stall mid row 0
      win_ready = 1'b1;
      pulse_start();
      chk("fill_in_ready", 72'(in_ready), 72'(1));
      for (int r = 0; r < 26; r++) begin
         for (int n = 0; n < 28; n++) begin
            in_valid = 1'b1;
            drive_col(r, n);
            if (r == 0 && n == 11) begin
               win_ready = 1'b0;
               repeat (5) begin
                  @(posedge clk); #1;
                  chk("stall_in_ready",  72'(in_ready),  72'(0));
                  chk("stall_win_valid", 72'(win_valid), 72'(1));
                  chk("stall_win_col",   72'(win_col),   72'(8));
                  chk("stall_win_data",  win_data,       win_exp(0, 8));
               end
               win_ready = 1'b1;
            end
            @(posedge clk); #1;
            if (n >= 2) begin
               chk("f1_valid", 72'(win_valid), 72'(1));
               chk("f1_row",   72'(win_row),   72'(r));
               chk("f1_col",   72'(win_col),   72'(n - 2));
               chk("f1_data",  win_data,       win_exp(r, n - 2));
            end else begin
               chk("f1_fill_novalid", 72'(win_valid), 72'(0));
            end
         end
      end
      in_valid = 1'b0;
      chk("drain_in_ready", 72'(in_ready), 72'(0));
      @(posedge clk); #1;
      chk("f1_frame_done",      72'(frame_done), 72'(1));
      chk("f1_done_win_valid",  72'(win_valid),  72'(0));
      @(posedge clk); #1;
      chk("f1_frame_done_pulse", 72'(frame_done), 72'(0));

      // Frame 2: random in_valid / win_ready, stray start mid-frame
      win_ready = 1'b1;
      pulse_start();
      got    = 0;
      fd_cnt = 0;
      cyc    = 0;
      held   = 1'b0;
      hdata  = '0;
      hcol   = '0;
      fork
         begin
            for (int r = 0; r < 26; r++) begin
               for (int n = 0; n < 28; n++) begin
                  logic acc;
                  int   waited;
                  if (r == 10 && n == 5) begin
                     in_valid = 1'b0;
                     pulse_start();
                  end
                  if ($urandom_range(0, 3) == 0) begin
                     in_valid = 1'b0;
                     @(posedge clk); #1;
                  end
                  in_valid = 1'b1;
                  drive_col(r, n);
                  waited = 0;
                  do begin
                     @(negedge clk);
                     acc = in_ready;
                     @(posedge clk); #1;
                     waited++;
                  end while (!acc && waited < 50);
                  if (!acc) chk("f2_accept_timeout", 72'(acc), 72'(1));
               end
            end
            in_valid = 1'b0;
         end
         begin
            while (cyc < 20000 && !(got == 676 && fd_cnt != 0)) begin
               @(posedge clk); #1;
               win_ready = ($urandom_range(0, 2) != 0);
               @(negedge clk);
               cyc++;
               if (frame_done) fd_cnt++;
               if (held) begin
                  chk("f2_hold_valid", 72'(win_valid), 72'(1));
                  chk("f2_hold_data",  win_data,       hdata);
                  chk("f2_hold_col",   72'(win_col),   72'(hcol));
               end
               held = 1'b0;
               if (win_valid) begin
                  if (win_ready) begin
                     chk("f2_row",  72'(win_row), 72'(got / 26));
                     chk("f2_col",  72'(win_col), 72'(got % 26));
                     chk("f2_data", win_data,     win_exp(got / 26, got % 26));
                     got++;
                  end else begin
                     held  = 1'b1;
                     hdata = win_data;
                     hcol  = win_col;
                  end
               end
            end
            repeat (10) begin
               @(negedge clk);
               if (frame_done) fd_cnt++;
            end
         end
      join
      chk("f2_window_count",     72'(got),    72'(676));
      chk("f2_frame_done_count", 72'(fd_cnt), 72'(1));

      // Frame 3: asynchronous reset mid-stream, then a clean restart
      @(posedge clk); #1;
      win_ready = 1'b1;
      pulse_start();
      for (int n = 0; n < 6; n++) begin
         in_valid = 1'b1;
         drive_col(0, n);
         @(posedge clk); #1;
      end
      chk("pre_rst_win_col", 72'(win_col), 72'(3));
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready",   72'(in_ready),   72'(0));
      chk("arst_win_valid",  72'(win_valid),  72'(0));
      chk("arst_win_data",   win_data,        72'(0));
      chk("arst_win_row",    72'(win_row),    72'(0));
      chk("arst_win_col",    72'(win_col),    72'(0));
      chk("arst_frame_done", 72'(frame_done), 72'(0));
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_start();
      for (int n = 0; n < 3; n++) begin
         in_valid = 1'b1;
         drive_col(1, n);
         @(posedge clk); #1;
         if (n < 2) chk("re_fill_novalid", 72'(win_valid), 72'(0));
      end
      in_valid = 1'b0;
      chk("re_valid", 72'(win_valid), 72'(1));
      chk("re_row",   72'(win_row),   72'(0));
      chk("re_col",   72'(win_col),   72'(0));
      chk("re_data",  win_data,       win_exp(1, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
